// File: rtl/l1_dcache_ctrl.sv
// l1_dcache_ctrl
// Direct-mapped, write-back, write-allocate L1 data cache. It sits between the
// CPU MEM stage and a block-wide Dmem. Hits complete in the same cycle. A miss
// stalls the CPU, writes back a dirty victim and then refills the line.
//
// Ports
//   clock, reset            : system clock and synchronous active-high reset
//   cpu_ren/cpu_wen         : load / store strobes (both high means store)
//   cpu_addr, cpu_wdata     : byte address and store data
//   cpu_rdata, cpu_stall    : combinational load data and stall
//   mem_ren/mem_wen         : registered Dmem read / write requests
//   mem_block_address       : registered {tag, index} block address
//   mem_din                 : registered victim block for write-back
//   mem_ready, mem_done     : Dmem idle flag and completion pulse
//   mem_dout                : refill block
//   hit_count, miss_count   : wrapping performance counters
module l1_dcache_ctrl #(
  parameter int NUM_LINES  = 8,
  parameter int BLOCK_W    = 256,
  parameter int WORD_W     = 32,
  parameter int MEM_ADDR_W = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_ren,
  input  logic                  cpu_wen,
  input  logic [31:0]           cpu_addr,
  input  logic [WORD_W-1:0]     cpu_wdata,
  output logic [WORD_W-1:0]     cpu_rdata,
  output logic                  cpu_stall,
  output logic                  mem_ren,
  output logic                  mem_wen,
  output logic [MEM_ADDR_W-1:0] mem_block_address,
  output logic [BLOCK_W-1:0]    mem_din,
  input  logic                  mem_ready,
  input  logic                  mem_done,
  input  logic [BLOCK_W-1:0]    mem_dout,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = MEM_ADDR_W - IDX_W;
  localparam int OFF_W = $clog2(BLOCK_W / WORD_W);
  localparam int TOP_B = 2 + OFF_W + IDX_W + TAG_W;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WB_REQ  = 3'd1,
    S_WB_WAIT = 3'd2,
    S_RF_REQ  = 3'd3,
    S_RF_WAIT = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [BLOCK_W-1:0]    data_q [NUM_LINES];
  logic [TAG_W-1:0]      tag_q  [NUM_LINES];
  logic [NUM_LINES-1:0]  valid_q, dirty_q;

  logic                  mem_ren_q, mem_ren_d;
  logic                  mem_wen_q, mem_wen_d;
  logic [MEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [BLOCK_W-1:0]    mem_din_q, mem_din_d;
  logic [31:0]           hit_cnt_q, hit_cnt_d;
  logic [31:0]           miss_cnt_q, miss_cnt_d;

  logic [OFF_W-1:0] word_s;
  logic [IDX_W-1:0] idx_s;
  logic [TAG_W-1:0] tag_s;
  logic             req_s, is_store_s, hit_s, idle_s;
  logic             store_hit_s, refill_s, wb_done_s;
  logic             unused_addr_s;

  assign word_s        = cpu_addr[2 +: OFF_W];
  assign idx_s         = cpu_addr[2 + OFF_W +: IDX_W];
  assign tag_s         = cpu_addr[2 + OFF_W + IDX_W +: TAG_W];
  assign unused_addr_s = ^{cpu_addr[31:TOP_B], cpu_addr[1:0]};

  assign req_s       = cpu_ren | cpu_wen;
  assign is_store_s  = cpu_wen;            // store wins when both strobes are high
  assign hit_s       = valid_q[idx_s] & (tag_q[idx_s] == tag_s);
  assign idle_s      = (state_q == S_IDLE);
  assign store_hit_s = idle_s & req_s & hit_s & is_store_s;
  assign refill_s    = (state_q == S_RF_WAIT) & mem_done;
  assign wb_done_s   = (state_q == S_WB_WAIT) & mem_done;

  assign cpu_stall = req_s & ~(idle_s & hit_s);
  assign cpu_rdata = data_q[idx_s][int'(word_s) * WORD_W +: WORD_W];

  assign mem_ren           = mem_ren_q;
  assign mem_wen           = mem_wen_q;
  assign mem_block_address = mem_addr_q;
  assign mem_din           = mem_din_q;
  assign hit_count         = hit_cnt_q;
  assign miss_count        = miss_cnt_q;

  // Next-state, Dmem request and counter logic.
  always_comb begin
    state_d    = state_q;
    mem_ren_d  = mem_ren_q;
    mem_wen_d  = mem_wen_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_s && hit_s) begin
          hit_cnt_d = hit_cnt_q + 32'd1;
        end else if (req_s) begin
          miss_cnt_d = miss_cnt_q + 32'd1;
          state_d    = (valid_q[idx_s] && dirty_q[idx_s]) ? S_WB_REQ : S_RF_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WB_REQ: begin
        if (mem_ready) begin
          mem_wen_d  = 1'b1;
          mem_addr_d = {tag_q[idx_s], idx_s};
          mem_din_d  = data_q[idx_s];
          state_d    = S_WB_WAIT;
        end else begin
          state_d = S_WB_REQ;
        end
      end
      S_WB_WAIT: begin
        if (mem_done) begin
          mem_wen_d = 1'b0;
          state_d   = S_RF_REQ;
        end else begin
          state_d = S_WB_WAIT;
        end
      end
      S_RF_REQ: begin
        if (mem_ready) begin
          mem_ren_d  = 1'b1;
          mem_addr_d = {tag_s, idx_s};
          state_d    = S_RF_WAIT;
        end else begin
          state_d = S_RF_REQ;
        end
      end
      S_RF_WAIT: begin
        if (mem_done) begin
          mem_ren_d = 1'b0;
          state_d   = S_IDLE;
        end else begin
          state_d = S_RF_WAIT;
        end
      end
      default: begin
        state_d   = S_IDLE;
        mem_ren_d = 1'b0;
        mem_wen_d = 1'b0;
      end
    endcase
  end

  // State, Dmem request and counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      mem_ren_q  <= 1'b0;
      mem_wen_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      mem_ren_q  <= mem_ren_d;
      mem_wen_q  <= mem_wen_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Line valid/dirty bits; reset invalidates everything and discards dirty data.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (refill_s) begin
      valid_q[idx_s] <= 1'b1;
      dirty_q[idx_s] <= 1'b0;
    end else if (wb_done_s) begin
      dirty_q[idx_s] <= 1'b0;
    end else if (store_hit_s) begin
      dirty_q[idx_s] <= 1'b1;
    end
  end

  // Line data and tags; deliberately left untouched by reset.
  always_ff @(posedge clock) begin
    if (refill_s) begin
      data_q[idx_s] <= mem_dout;
      tag_q[idx_s]  <= tag_s;
    end else if (store_hit_s) begin
      data_q[idx_s][int'(word_s) * WORD_W +: WORD_W] <= cpu_wdata;
    end
  end

endmodule

// File: tb/tb_l1_dcache_ctrl.sv
// Directed bench for l1_dcache_ctrl with a behavioural Dmem model.
// Expected load data and expected Dmem transactions are queued when each
// request is driven, and they are compared when the DUT completes the request.
module tb_l1_dcache_ctrl;

  localparam int LAT = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic         cpu_ren, cpu_wen;
  logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
  logic         cpu_stall;
  logic         mem_ren, mem_wen;
  logic [4:0]   mem_block_address;
  logic [255:0] mem_din, mem_dout;
  logic         mem_ready, mem_done;
  logic [31:0]  hit_count, miss_count;

  logic         ready_en;

  typedef struct packed {
    logic         wr;
    logic [4:0]   addr;
    logic [255:0] din;
  } mem_txn_t;

  // Dmem model state
  logic [255:0] mem_arr [32];
  logic         busy = 1'b0;
  logic         done_r = 1'b0;
  int           cnt = 0;
  logic         cur_wr = 1'b0;
  logic [4:0]   cur_addr = 5'd0;
  logic [255:0] dout_r = '0;
  logic         both_err = 1'b0;
  mem_txn_t     obs_arr [64];
  int           nobs = 0;

  // Scoreboard state
  mem_txn_t     exp_mem_q [$];
  logic [31:0]  exp_rd_q [$];
  int           seen = 0;
  int           checks = 0;
  int           passes = 0;
  int           stalls;

  always #5 clock = ~clock;

  assign mem_ready = ready_en & ~busy & ~done_r;
  assign mem_done  = done_r;
  assign mem_dout  = dout_r;

  l1_dcache_ctrl dut (
    .clock             (clock),
    .reset             (reset),
    .cpu_ren           (cpu_ren),
    .cpu_wen           (cpu_wen),
    .cpu_addr          (cpu_addr),
    .cpu_wdata         (cpu_wdata),
    .cpu_rdata         (cpu_rdata),
    .cpu_stall         (cpu_stall),
    .mem_ren           (mem_ren),
    .mem_wen           (mem_wen),
    .mem_block_address (mem_block_address),
    .mem_din           (mem_din),
    .mem_ready         (mem_ready),
    .mem_done          (mem_done),
    .mem_dout          (mem_dout),
    .hit_count         (hit_count),
    .miss_count        (miss_count)
  );

  function automatic logic [31:0] init_word(input int b, input int w);
    return 32'hA000_0000 | 32'(b * 256 + w);
  endfunction

  function automatic logic [255:0] init_block(input int b);
    logic [255:0] blk;
    for (int w = 0; w < 8; w++) blk[w*32 +: 32] = init_word(b, w);
    return blk;
  endfunction

  // Dmem: accepts one request when idle, completes LAT+1 cycles later with a done pulse.
  always @(posedge clock) begin
    if (reset) begin
      busy   <= 1'b0;
      done_r <= 1'b0;
      cnt    <= 0;
      for (int b = 0; b < 32; b++) mem_arr[b] <= init_block(b);
    end else if (done_r) begin
      done_r <= 1'b0;
      busy   <= 1'b0;
    end else if (busy) begin
      if (cnt == 0) begin
        done_r <= 1'b1;
        if (!cur_wr) dout_r <= mem_arr[cur_addr];
      end else begin
        cnt <= cnt - 1;
      end
    end else if (mem_ren || mem_wen) begin
      busy     <= 1'b1;
      cnt      <= LAT;
      cur_wr   <= mem_wen;
      cur_addr <= mem_block_address;
      if (mem_wen) mem_arr[mem_block_address] <= mem_din;
      if (mem_ren && mem_wen) both_err <= 1'b1;
      obs_arr[nobs] <= '{wr: mem_wen, addr: mem_block_address, din: mem_din};
      nobs <= nobs + 1;
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic push_mem(input logic wr, input logic [4:0] addr, input logic [255:0] din);
    exp_mem_q.push_back('{wr: wr, addr: addr, din: din});
  endtask

  task automatic check_mem(input string tag);
    mem_txn_t e, o;
    chk({tag, "_ntxn"}, 256'(nobs - seen), 256'(exp_mem_q.size()));
    while (seen < nobs && exp_mem_q.size() > 0) begin
      e = exp_mem_q.pop_front();
      o = obs_arr[seen];
      seen++;
      chk({tag, "_wr"}, 256'(o.wr), 256'(e.wr));
      chk({tag, "_addr"}, 256'(o.addr), 256'(e.addr));
      if (e.wr) chk({tag, "_din"}, o.din, e.din);
    end
    exp_mem_q.delete();
    seen = nobs;
  endtask

  task automatic start_req(input logic ren, input logic wen, input logic [31:0] addr,
                           input logic [31:0] wdata);
    @(negedge clock);
    cpu_ren   = ren;
    cpu_wen   = wen;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    #1;
  endtask

  task automatic finish_req(input string tag, output int n);
    n = 0;
    while (cpu_stall === 1'b1 && n < 300) begin
      @(negedge clock);
      #1;
      n++;
    end
    chk({tag, "_no_timeout"}, 256'(cpu_stall === 1'b0), 256'(1));
    if (cpu_ren && !cpu_wen && exp_rd_q.size() > 0)
      chk({tag, "_rdata"}, 256'(cpu_rdata), 256'(exp_rd_q.pop_front()));
    @(negedge clock);
    cpu_ren = 1'b0;
    cpu_wen = 1'b0;
    #1;
  endtask

  task automatic do_load(input string tag, input logic [31:0] addr, input logic [31:0] exp,
                         output int n);
    exp_rd_q.push_back(exp);
    start_req(1'b1, 1'b0, addr, 32'd0);
    finish_req(tag, n);
  endtask

  task automatic do_store(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                          output int n);
    start_req(1'b0, 1'b1, addr, wdata);
    finish_req(tag, n);
  endtask

  initial begin
    logic [255:0] blk;
    int w;
    reset     = 1'b1;
    cpu_ren   = 1'b0;
    cpu_wen   = 1'b0;
    cpu_addr  = 32'd0;
    cpu_wdata = 32'd0;
    ready_en  = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    chk("rst_mem_ren", 256'(mem_ren), 256'(0));
    chk("rst_mem_wen", 256'(mem_wen), 256'(0));
    chk("rst_addr", 256'(mem_block_address), 256'(0));
    chk("rst_din", mem_din, 256'(0));
    chk("rst_hits", 256'(hit_count), 256'(0));
    chk("rst_misses", 256'(miss_count), 256'(0));
    chk("rst_stall", 256'(cpu_stall), 256'(0));
    @(negedge clock);
    reset = 1'b0;

    // Cold load miss on block 0
    push_mem(1'b0, 5'd0, 256'd0);
    exp_rd_q.push_back(init_word(0, 0));
    start_req(1'b1, 1'b0, 32'h000, 32'd0);
    chk("ld0_stall", 256'(cpu_stall), 256'(1));
    finish_req("ld0", stalls);
    chk("ld0_misses", 256'(miss_count), 256'(1));
    chk("ld0_hits", 256'(hit_count), 256'(1));
    check_mem("ld0_mem");

    // Store miss allocates block 1, following load hits with zero stall
    push_mem(1'b0, 5'd1, 256'd0);
    do_store("st24", 32'h024, 32'hDEAD_BEEF, stalls);
    do_load("ld24", 32'h024, 32'hDEAD_BEEF, stalls);
    chk("ld24_stalls", 256'(stalls), 256'(0));
    check_mem("st24_mem");
    chk("st24_hits", 256'(hit_count), 256'(3));
    chk("st24_misses", 256'(miss_count), 256'(2));

    // Conflict on index 1: dirty victim written back before refill of block 9
    blk = init_block(1);
    blk[32 +: 32] = 32'hDEAD_BEEF;
    push_mem(1'b1, 5'd1, blk);
    push_mem(1'b0, 5'd9, 256'd0);
    do_load("ld124", 32'h124, init_word(9, 1), stalls);
    check_mem("ld124_mem");
    chk("ld124_misses", 256'(miss_count), 256'(3));
    chk("ld124_hits", 256'(hit_count), 256'(4));

    // Reload block 1: clean victim, written-back data must come back from Dmem
    push_mem(1'b0, 5'd1, 256'd0);
    do_load("reld24", 32'h024, 32'hDEAD_BEEF, stalls);
    check_mem("reld24_mem");

    // Both strobes high acts as a store
    push_mem(1'b0, 5'd2, 256'd0);
    start_req(1'b1, 1'b1, 32'h040, 32'h0000_0005);
    finish_req("both40", stalls);
    do_load("ld40", 32'h040, 32'h0000_0005, stalls);
    chk("ld40_stalls", 256'(stalls), 256'(0));
    check_mem("both40_mem");
    blk = init_block(2);
    blk[0 +: 32] = 32'h0000_0005;
    push_mem(1'b1, 5'd2, blk);
    push_mem(1'b0, 5'd10, 256'd0);
    do_load("ld140", 32'h140, init_word(10, 0), stalls);
    check_mem("ld140_mem");
    chk("ld140_misses", 256'(miss_count), 256'(6));
    chk("ld140_hits", 256'(hit_count), 256'(8));

    // Dmem not ready for 10 cycles during a miss
    ready_en = 1'b0;
    push_mem(1'b0, 5'd3, 256'd0);
    exp_rd_q.push_back(init_word(3, 0));
    start_req(1'b1, 1'b0, 32'h060, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      #1;
      chk("nrdy_mem_ren", 256'(mem_ren), 256'(0));
      chk("nrdy_stall", 256'(cpu_stall), 256'(1));
    end
    ready_en = 1'b1;
    @(negedge clock);
    #1;
    chk("rdy_mem_ren", 256'(mem_ren), 256'(1));
    finish_req("ld60", stalls);
    check_mem("ld60_mem");
    chk("ld60_misses", 256'(miss_count), 256'(7));

    // Reset while the refill is outstanding
    push_mem(1'b0, 5'd4, 256'd0);
    start_req(1'b1, 1'b0, 32'h080, 32'd0);
    w = 0;
    while (mem_ren !== 1'b1 && w < 50) begin
      @(negedge clock);
      #1;
      w++;
    end
    chk("rfw_reached", 256'(mem_ren), 256'(1));
    @(negedge clock);
    reset   = 1'b1;
    cpu_ren = 1'b0;
    @(negedge clock);
    #1;
    chk("mid_rst_mem_ren", 256'(mem_ren), 256'(0));
    chk("mid_rst_hits", 256'(hit_count), 256'(0));
    chk("mid_rst_misses", 256'(miss_count), 256'(0));
    chk("mid_rst_stall", 256'(cpu_stall), 256'(0));
    check_mem("mid_rst_mem");
    reset = 1'b0;

    push_mem(1'b0, 5'd4, 256'd0);
    do_load("ld80_again", 32'h080, init_word(4, 0), stalls);
    chk("ld80_missed", 256'(stalls > 0), 256'(1));
    push_mem(1'b0, 5'd0, 256'd0);
    do_load("ld0_again", 32'h000, init_word(0, 0), stalls);
    check_mem("post_rst_mem");
    chk("post_rst_misses", 256'(miss_count), 256'(2));
    chk("post_rst_hits", 256'(hit_count), 256'(2));

    chk("never_both_strobes", 256'(both_err), 256'(0));
    chk("rdata_queue_empty", 256'(exp_rd_q.size()), 256'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
